fetch_pc_gen: RTL and testbench



---
 rtl/fetch_pc_gen_if.sv | 31 +++
 rtl/fetch_pc_gen.sv | 127 ++++++++++++
 tb/tb_fetch_pc_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: bundle between hazard control and the fetch PC generator.
//   master : hazard/control side; drives i_stall, load_pc_we, load_pc_new_pc.
//   slave  : fetch_pc_gen side; drives fetch_pc, fetch_valid, redirect_pending,
//            misaligned_redirect and the three perf_* counters.
interface fetch_pc_gen_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              i_stall;
    logic              load_pc_we;
    logic [ADDR_W-1:0] load_pc_new_pc;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_valid;
    logic              redirect_pending;
    logic              misaligned_redirect;
    logic [CNT_W-1:0]  perf_fetch_cnt;
    logic [CNT_W-1:0]  perf_stall_cnt;
    logic [CNT_W-1:0]  perf_redirect_cnt;

    modport master (
        output i_stall, load_pc_we, load_pc_new_pc,
        input  fetch_pc, fetch_valid, redirect_pending, misaligned_redirect,
        input  perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt
    );

    modport slave (
        input  i_stall, load_pc_we, load_pc_new_pc,
        output fetch_pc, fetch_valid, redirect_pending, misaligned_redirect,
        output perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: IF-stage fetch PC generator.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_pc_gen_if.slave
//              in : i_stall, load_pc_we, load_pc_new_pc
//              out: fetch_pc, fetch_valid, redirect_pending, misaligned_redirect,
//                   perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt
// A redirect arriving while IF is stalled is parked in HOLD and applied on
// stall release; a redirect on the release cycle itself overrides the parked one.
// Optional: FETCH_PERF_CNT_EN builds the saturating perf counters; otherwise the
// perf_* outputs are tied to zero.
module fetch_pc_gen #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    fetch_pc_gen_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_q, pend_d;
    logic              valid_q, valid_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] tgt_aligned;

    assign tgt_aligned = {bus.load_pc_new_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pend_d    = pend_q;
        valid_d   = valid_q;
        mis_d     = 1'b0;
        case (state_q)
            BOOT: begin
                // Inputs ignored; first real request is RESET_PC itself.
                valid_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                mis_d = bus.load_pc_we & (bus.load_pc_new_pc[1:0] != 2'b00);
                if (bus.load_pc_we && !bus.i_stall) begin
                    pc_d = tgt_aligned;
                end else if (bus.load_pc_we && bus.i_stall) begin
                    pend_pc_d = tgt_aligned;
                    pend_d    = 1'b1;
                    state_d   = HOLD;
                end else if (!bus.i_stall) begin
                    pc_d = pc_q + ADDR_W'(4);
                end
            end
            HOLD: begin
                mis_d = bus.load_pc_we & (bus.load_pc_new_pc[1:0] != 2'b00);
                if (bus.i_stall) begin
                    if (bus.load_pc_we) pend_pc_d = tgt_aligned;
                end else begin
                    // Release cycle loads the target only; no +4 this cycle.
                    pc_d    = bus.load_pc_we ? tgt_aligned : pend_pc_q;
                    pend_d  = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
                pend_d  = 1'b0;
                pc_d    = RESET_PC;
            end
        endcase
    end

    assign bus.fetch_pc            = pc_q;
    assign bus.fetch_valid         = valid_q;
    assign bus.redirect_pending    = pend_q;
    assign bus.misaligned_redirect = mis_q;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fcnt_q, scnt_q, rcnt_q;
    logic             run_like;

    // valid_q is low only in BOOT, so it also marks "outside BOOT".
    assign run_like = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q <= '0;
            scnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            if (run_like && !bus.i_stall && fcnt_q != '1) fcnt_q <= fcnt_q + 1'b1;
            if (run_like &&  bus.i_stall && scnt_q != '1) scnt_q <= scnt_q + 1'b1;
            if (run_like && bus.load_pc_we && rcnt_q != '1) rcnt_q <= rcnt_q + 1'b1;
        end
    end

    assign bus.perf_fetch_cnt    = fcnt_q;
    assign bus.perf_stall_cnt    = scnt_q;
    assign bus.perf_redirect_cnt = rcnt_q;
`else
    assign bus.perf_fetch_cnt    = {CNT_W{1'b0}};
    assign bus.perf_stall_cnt    = {CNT_W{1'b0}};
    assign bus.perf_redirect_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    fetch_pc_gen #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural view of the fetch unit.
    bit          m_booting;
    bit          m_valid;
    logic [31:0] m_pc;
    bit          m_parked;
    logic [31:0] m_park_pc;
    bit          m_mis;
    int          m_fc, m_sc, m_rc;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_booting = 1; m_valid = 0; m_pc = RESET_PC;
        m_parked = 0; m_park_pc = 0; m_mis = 0;
        m_fc = 0; m_sc = 0; m_rc = 0;
    endtask

    task automatic model_clock(input bit stall, input bit we, input logic [31:0] npc);
        logic [31:0] tgt;
        tgt = npc & 32'hFFFF_FFFC;
        if (m_booting) begin
            m_booting = 0;
            m_valid   = 1;
            m_mis     = 0;
            return;
        end
        m_mis = we && (npc % 4 != 0);
        if (!stall) m_fc = sat(m_fc); else m_sc = sat(m_sc);
        if (we) m_rc = sat(m_rc);
        if (m_parked) begin
            if (stall) begin
                if (we) m_park_pc = tgt;        // newest wins
            end else begin
                m_pc = we ? tgt : m_park_pc;    // incoming beats parked
                m_parked = 0;
            end
        end else if (we) begin
            if (stall) begin m_parked = 1; m_park_pc = tgt; end
            else m_pc = tgt;
        end else if (!stall) begin
            m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
    endtask

    task automatic check_all(input string tag);
        int efc, esc, erc;
`ifdef FETCH_PERF_CNT_EN
        efc = m_fc; esc = m_sc; erc = m_rc;
`else
        efc = 0; esc = 0; erc = 0;
`endif
        chk({tag, ".pc"},    64'(bus.fetch_pc), 64'(m_pc));
        chk({tag, ".valid"}, 64'(bus.fetch_valid), 64'(m_valid));
        chk({tag, ".pend"},  64'(bus.redirect_pending), 64'(m_parked));
        chk({tag, ".mis"},   64'(bus.misaligned_redirect), 64'(m_mis));
        chk({tag, ".fcnt"},  64'(bus.perf_fetch_cnt), 64'(efc));
        chk({tag, ".scnt"},  64'(bus.perf_stall_cnt), 64'(esc));
        chk({tag, ".rcnt"},  64'(bus.perf_redirect_cnt), 64'(erc));
    endtask

    // Inputs change 1 time unit after posedge; outputs checked 1 unit after the next posedge.
    task automatic step(input string tag, input bit stall, input bit we, input logic [31:0] npc);
        bus.i_stall = stall;
        bus.load_pc_we = we;
        bus.load_pc_new_pc = npc;
        @(posedge clk);
        model_clock(stall, we, npc);
        #1;
        check_all(tag);
    endtask

    // Async reset pulse mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.i_stall = 0; bus.load_pc_we = 0; bus.load_pc_new_pc = 0;
    endtask

    initial begin
        bus.i_stall = 0; bus.load_pc_we = 0; bus.load_pc_new_pc = 0;
        model_reset();
        #3;
        check_all("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Boot then sequential fetch: 0,0,4,8,C
        step("boot", 0, 0, 0);
        step("seq4", 0, 0, 0);
        step("seq8", 0, 0, 0);
        step("seqC", 0, 0, 0);

        // Plain redirect
        step("to100", 0, 1, 32'h100);
        step("rd2000", 0, 1, 32'h2000);
        step("inc2004", 0, 0, 0);

        // Redirect during stall, held 3 cycles
        step("to40", 0, 1, 32'h40);
        step("hold1", 1, 1, 32'h800);
        step("hold2", 1, 0, 0);
        step("hold3", 1, 0, 0);
        step("rel800", 0, 0, 0);
        step("after800", 0, 0, 0);

        // Newest parked redirect wins
        step("park800", 1, 1, 32'h800);
        step("park900", 1, 1, 32'h900);
        step("rel900", 0, 0, 0);

        // Incoming beats parked on release
        step("park800b", 1, 1, 32'h800);
        step("relA00", 0, 1, 32'hA00);

        // Misaligned target
        step("mis1003", 0, 1, 32'h1003);
        step("misoff", 0, 0, 0);
        step("mishold", 1, 1, 32'h2002);
        step("misrel", 0, 0, 0);

        // Wrap
        step("toFFFC", 0, 1, 32'hFFFF_FFFC);
        step("wrap0", 0, 0, 0);

        // Reset while a redirect is parked, then stall saturation
        step("park500", 1, 1, 32'h500);
        do_reset("rst_hold");
        step("boot2", 0, 0, 0);
        for (int i = 0; i < 5; i++) step("satstall", 1, 0, 0);
        for (int i = 0; i < 4; i++) step("satfetch", 0, 0, 0);

        // Random phase
        for (int i = 0; i < 800; i++) begin
            bit s, w;
            logic [31:0] p;
            if ($urandom_range(0, 99) < 2) begin
                do_reset("rnd_rst");
            end else begin
                s = ($urandom_range(0, 99) < 35);
                w = ($urandom_range(0, 99) < 25);
                p = $urandom;
                if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
                step("rnd", s, w, p);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
